ma_stage: RTL and testbench

- Memory-access stage, directly downstream of the EX/MA pipeline register; consumes its control bits, ALU result (address) and store data.
- Runs a request/response handshake with the data memory and performs store byte-lane steering and load extension.
- Holds the pipeline with stallOut until each access completes.
- Flags misaligned accesses and bus timeouts.

---
 rtl/ma_stage.sv | 163 ++++++++++++++++
 tb/tb_ma_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// Memory-access stage: drives the data-memory request/response handshake,
// steers store byte lanes, extends load data and stalls the pipeline per access.
module ma_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clkIn,
    input  logic        resetIn,
    input  logic        validIn,
    input  logic        memReadIn,
    input  logic        memWriteIn,
    input  logic [2:0]  memOpIn,
    input  logic [31:0] addrIn,
    input  logic [31:0] storeDataIn,
    output logic        dmemReqOut,
    output logic        dmemWeOut,
    output logic [31:0] dmemAddrOut,
    output logic [31:0] dmemWdataOut,
    output logic [3:0]  dmemBeOut,
    input  logic        dmemReadyIn,
    input  logic        dmemRvalidIn,
    input  logic [31:0] dmemRdataIn,
    output logic        stallOut,
    output logic [31:0] loadDataOut,
    output logic        loadValidOut,
    output logic        misalignOut,
    output logic        busErrOut
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt;
    logic [29:0]        addr_q;
    logic [2:0]         op_q;
    logic [1:0]         lane_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        load_data_q;
    logic               load_valid_q;
    logic               bus_err_q;

    logic               access, is_byte, is_half, mis, start, timeout_hit;
    logic [1:0]         lane;
    logic [31:0]        wdata_d;
    logic [3:0]         be_d;

    assign lane        = addrIn[1:0];
    assign access      = memReadIn | memWriteIn;
    assign is_byte     = (memOpIn == 3'b000) | (memOpIn == 3'b100);
    assign is_half     = (memOpIn == 3'b001) | (memOpIn == 3'b101);
    assign mis         = (is_half & addrIn[0]) | (~is_byte & ~is_half & (lane != 2'b00));
    assign start       = validIn & access & ~mis;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

    // Store lane steering; loads always request the full word.
    always_comb begin
        wdata_d = storeDataIn;
        be_d    = 4'b1111;
        if (memWriteIn) begin
            if (is_byte) begin
                wdata_d = {4{storeDataIn[7:0]}};
                be_d    = 4'b0001 << lane;
            end else if (is_half) begin
                wdata_d = {2{storeDataIn[15:0]}};
                be_d    = lane[1] ? 4'b1100 : 4'b0011;
            end
        end
    end

    function automatic logic [31:0] extend(input logic [2:0]  op,
                                           input logic [1:0]  l,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{l, 3'b000} +: 8];
        h = l[1] ? word[31:16] : word[15:0];
        case (op)
            3'b000:  extend = {{24{b[7]}}, b};
            3'b001:  extend = {{16{h[15]}}, h};
            3'b100:  extend = {24'h0, b};
            3'b101:  extend = {16'h0, h};
            default: extend = word;
        endcase
    endfunction

    // NOTE: every output written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state;
        stallOut    = 1'b0;
        dmemReqOut  = 1'b0;
        misalignOut = 1'b0;
        case (state)
            S_IDLE: begin
                misalignOut = validIn & access & mis;
                if (start) begin
                    stallOut = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                dmemReqOut = 1'b1;
                stallOut   = 1'b1;
                if (dmemReadyIn)      state_d = we_q ? S_DONE : S_WAIT;
                else if (timeout_hit) state_d = S_DONE;
            end
            S_WAIT: begin
                stallOut = 1'b1;
                if (dmemRvalidIn || timeout_hit) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            op_q         <= '0;
            lane_q       <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state        <= state_d;
            load_valid_q <= (state == S_WAIT) & dmemRvalidIn;
            bus_err_q    <= timeout_hit & (((state == S_REQ) & ~dmemReadyIn) |
                                           ((state == S_WAIT) & ~dmemRvalidIn));
            if ((state == S_IDLE) && start) begin
                addr_q  <= addrIn[31:2];
                op_q    <= memOpIn;
                lane_q  <= lane;
                we_q    <= memWriteIn;
                be_q    <= be_d;
                wdata_q <= wdata_d;
                cnt     <= '0;
            end
            if ((state == S_REQ) || (state == S_WAIT)) cnt <= cnt + 1'b1;
            if ((state == S_WAIT) && dmemRvalidIn)
                load_data_q <= extend(op_q, lane_q, dmemRdataIn);
        end
    end

    assign dmemWeOut    = we_q & (state == S_REQ);
    assign dmemAddrOut  = {addr_q, 2'b00};
    assign dmemWdataOut = wdata_q;
    assign dmemBeOut    = be_q;
    assign loadDataOut  = load_data_q;
    assign loadValidOut = load_valid_q;
    assign busErrOut    = bus_err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Directed bench for ma_stage: stores, loads with extension, misalignment,
// bus timeout and reset during an outstanding load.
module tb_ma_stage;

    logic        clk = 1'b0;
    logic        resetIn, validIn, memReadIn, memWriteIn;
    logic [2:0]  memOpIn;
    logic [31:0] addrIn, storeDataIn;
    logic        dmemReqOut, dmemWeOut;
    logic [31:0] dmemAddrOut, dmemWdataOut;
    logic [3:0]  dmemBeOut;
    logic        dmemReadyIn, dmemRvalidIn;
    logic [31:0] dmemRdataIn;
    logic        stallOut;
    logic [31:0] loadDataOut;
    logic        loadValidOut, misalignOut, busErrOut;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ma_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clkIn(clk), .resetIn(resetIn), .validIn(validIn),
        .memReadIn(memReadIn), .memWriteIn(memWriteIn), .memOpIn(memOpIn),
        .addrIn(addrIn), .storeDataIn(storeDataIn),
        .dmemReqOut(dmemReqOut), .dmemWeOut(dmemWeOut), .dmemAddrOut(dmemAddrOut),
        .dmemWdataOut(dmemWdataOut), .dmemBeOut(dmemBeOut),
        .dmemReadyIn(dmemReadyIn), .dmemRvalidIn(dmemRvalidIn), .dmemRdataIn(dmemRdataIn),
        .stallOut(stallOut), .loadDataOut(loadDataOut), .loadValidOut(loadValidOut),
        .misalignOut(misalignOut), .busErrOut(busErrOut)
    );

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic idle_inputs();
        validIn = 0; memReadIn = 0; memWriteIn = 0; memOpIn = 3'b010;
        addrIn = 0; storeDataIn = 0; dmemReadyIn = 0; dmemRvalidIn = 0; dmemRdataIn = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetIn = 1;
        repeat (2) @(negedge clk);
        resetIn = 0;
        #1;
        total++; if (dmemReqOut !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", dmemReqOut); end
        total++; if (dmemWeOut !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", dmemWeOut); end
        total++; if (stallOut !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stallOut); end
        total++; if (loadDataOut !== 32'h0) begin bad++; $display("FAIL rst_ldata got=%h exp=0", loadDataOut); end
        total++; if ({loadValidOut, busErrOut, misalignOut} !== 3'b000) begin bad++;
            $display("FAIL rst_flags got=%b exp=000", {loadValidOut, busErrOut, misalignOut}); end
    endtask

    task automatic test_store_byte();
        @(negedge clk);
        validIn = 1; memWriteIn = 1; memOpIn = 3'b000; addrIn = 32'h1003; storeDataIn = 32'h0000_00AB;
        #1;
        total++; if (stallOut !== 1'b1) begin bad++; $display("FAIL sb_stall_idle got=%0b exp=1", stallOut); end
        total++; if (dmemReqOut !== 1'b0) begin bad++; $display("FAIL sb_req_idle got=%0b exp=0", dmemReqOut); end
        @(negedge clk);
        validIn = 0; memWriteIn = 0; dmemReadyIn = 1;
        #1;
        total++; if ({dmemReqOut, dmemWeOut, stallOut} !== 3'b111) begin bad++;
            $display("FAIL sb_req got=%b exp=111", {dmemReqOut, dmemWeOut, stallOut}); end
        total++; if (dmemAddrOut !== 32'h1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", dmemAddrOut); end
        total++; if (dmemBeOut !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b exp=1000", dmemBeOut); end
        total++; if (dmemWdataOut !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h exp=ababab ab", dmemWdataOut); end
        @(negedge clk);
        dmemReadyIn = 0;
        #1;
        total++; if ({dmemReqOut, stallOut, loadValidOut} !== 3'b000) begin bad++;
            $display("FAIL sb_done got=%b exp=000", {dmemReqOut, stallOut, loadValidOut}); end
        @(negedge clk);
    endtask

    task automatic test_store_half_word();
        // SH at lane 2 and SW: lanes and data checked in the REQ cycle.
        @(negedge clk);
        validIn = 1; memWriteIn = 1; memOpIn = 3'b001; addrIn = 32'h50A6; storeDataIn = 32'h1234_BEEF;
        @(negedge clk);
        validIn = 0; memWriteIn = 0; dmemReadyIn = 1;
        #1;
        total++; if ({dmemBeOut, dmemWdataOut, dmemAddrOut} !== {4'b1100, 32'hBEEF_BEEF, 32'h50A4}) begin bad++;
            $display("FAIL sh_lanes got=%b %h %h exp=1100 beefbeef 000050a4", dmemBeOut, dmemWdataOut, dmemAddrOut); end
        @(negedge clk);
        dmemReadyIn = 0;
        @(negedge clk);
        validIn = 1; memWriteIn = 1; memOpIn = 3'b010; addrIn = 32'h0000_0040; storeDataIn = 32'hCAFE_F00D;
        @(negedge clk);
        validIn = 0; memWriteIn = 0; dmemReadyIn = 1;
        #1;
        total++; if ({dmemBeOut, dmemWdataOut} !== {4'b1111, 32'hCAFE_F00D}) begin bad++;
            $display("FAIL sw_lanes got=%b %h exp=1111 cafef00d", dmemBeOut, dmemWdataOut); end
        @(negedge clk);
        dmemReadyIn = 0;
        @(negedge clk);
    endtask

    // Load with ready on the 1st REQ cycle and rvalid two cycles after ready.
    task automatic run_load(input string name, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
        @(negedge clk);
        validIn = 1; memReadIn = 1; memOpIn = op; addrIn = addr;
        @(negedge clk);
        validIn = 0; memReadIn = 0; dmemReadyIn = 1;
        #1;
        total++; if ({dmemReqOut, dmemWeOut, dmemBeOut} !== 6'b10_1111) begin bad++;
            $display("FAIL %s_req got=%b exp=101111", name, {dmemReqOut, dmemWeOut, dmemBeOut}); end
        @(negedge clk);
        dmemReadyIn = 0;
        #1;
        total++; if ({dmemReqOut, stallOut} !== 2'b01) begin bad++;
            $display("FAIL %s_wait got=%b exp=01", name, {dmemReqOut, stallOut}); end
        @(negedge clk);
        dmemRvalidIn = 1; dmemRdataIn = rdata;
        @(negedge clk);
        dmemRvalidIn = 0; dmemRdataIn = 32'h0;
        #1;
        total++; if ({loadValidOut, stallOut} !== 2'b10) begin bad++;
            $display("FAIL %s_done got=%b exp=10", name, {loadValidOut, stallOut}); end
        total++; if (loadDataOut !== exp) begin bad++; $display("FAIL %s_data got=%h exp=%h", name, loadDataOut, exp); end
        @(negedge clk);
        #1;
        total++; if (loadValidOut !== 1'b0 || loadDataOut !== exp) begin bad++;
            $display("FAIL %s_hold got=%b %h exp=0 %h", name, loadValidOut, loadDataOut, exp); end
    endtask

    task automatic test_loads();
        run_load("lb",  3'b000, 32'h2002, 32'h12F4_5678, 32'hFFFF_FFF4);
        run_load("lbu", 3'b100, 32'h2002, 32'h12F4_5678, 32'h0000_00F4);
        run_load("lh",  3'b001, 32'h2002, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lhu", 3'b101, 32'h2000, 32'h8001_7FFF, 32'h0000_7FFF);
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        validIn = 1; memReadIn = 1; memOpIn = 3'b010; addrIn = 32'h3001;
        #1;
        total++; if ({misalignOut, dmemReqOut, stallOut} !== 3'b100) begin bad++;
            $display("FAIL mis_idle got=%b exp=100", {misalignOut, dmemReqOut, stallOut}); end
        @(negedge clk);
        #1;
        total++; if ({dmemReqOut, stallOut} !== 2'b00) begin bad++;
            $display("FAIL mis_next got=%b exp=00", {dmemReqOut, stallOut}); end
        memOpIn = 3'b001; addrIn = 32'h3002;
        #1;
        total++; if (misalignOut !== 1'b0) begin bad++; $display("FAIL mis_lh_ok got=%0b exp=0", misalignOut); end
        validIn = 0; memReadIn = 0;
    endtask

    task automatic test_timeout();
        int req_cycles;
        @(negedge clk);
        validIn = 1; memReadIn = 1; memOpIn = 3'b010; addrIn = 32'h4000;
        @(negedge clk);
        validIn = 0; memReadIn = 0;
        req_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (dmemReqOut !== 1'b1) break;
            req_cycles++;
            @(negedge clk);
        end
        total++; if (req_cycles != 16) begin bad++; $display("FAIL to_req_cycles got=%0d exp=16", req_cycles); end
        total++; if ({busErrOut, stallOut, loadValidOut} !== 3'b100) begin bad++;
            $display("FAIL to_done got=%b exp=100", {busErrOut, stallOut, loadValidOut}); end
        total++; if (loadDataOut !== 32'h0000_7FFF) begin bad++; $display("FAIL to_ldata got=%h exp=00007fff", loadDataOut); end
        @(negedge clk);
        #1;
        total++; if (busErrOut !== 1'b0) begin bad++; $display("FAIL to_pulse got=%0b exp=0", busErrOut); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        validIn = 1; memReadIn = 1; memOpIn = 3'b010; addrIn = 32'h6000;
        @(negedge clk);
        validIn = 0; memReadIn = 0; dmemReadyIn = 1;
        @(negedge clk);
        dmemReadyIn = 0; resetIn = 1;
        @(negedge clk);
        resetIn = 0;
        #1;
        total++; if ({dmemReqOut, dmemWeOut, stallOut, loadValidOut, busErrOut} !== 5'b0) begin bad++;
            $display("FAIL rw_flags got=%b exp=00000", {dmemReqOut, dmemWeOut, stallOut, loadValidOut, busErrOut}); end
        total++; if ({dmemAddrOut, loadDataOut} !== 64'h0) begin bad++;
            $display("FAIL rw_regs got=%h %h exp=0 0", dmemAddrOut, loadDataOut); end
        dmemRvalidIn = 1; dmemRdataIn = 32'hDEAD_BEEF;
        @(negedge clk);
        dmemRvalidIn = 0;
        #1;
        total++; if ({loadValidOut, stallOut} !== 2'b00 || loadDataOut !== 32'h0) begin bad++;
            $display("FAIL rw_late got=%b %h exp=00 0", {loadValidOut, stallOut}, loadDataOut); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_store_half_word();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
